exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the five-stage LoongArch pipeline. Sits between decode (ds) and mem_stage.
- Computes the ALU result through the team's `alu` submodule (12-bit alu_op, src1, src2 -> 32-bit result).
- Runs an iterative 32-bit divider for div/mod ops and issues load/store requests to a synchronous data SRAM.
- Packs the 82-bit ES_TO_MS bus consumed by mem_stage and drives the ES forward bus to decode.

Parameters:
- DS_TO_ES_BUS_WD, 160, width of the bus from decode.
- ES_TO_MS_BUS_WD, 82, width of the bus to mem_stage.
- ES_FORWARD_WD, 72, width of the forward bus to decode.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ms_allowin  in  1  mem_stage can accept
- es_allowin  out  1  ES can accept
- ds_to_es_valid  in  1  decode offers an instruction
- ds_to_es_bus  in  160  {mem_we[159], ld_w,ld_b,ld_bu,ld_h,ld_hu,st_w,st_b,st_h[158:151], res_from_mem[150], gr_we[149], dest[148:144], div_op{mod_wu,mod_w,div_wu,div_w}[143:140], alu_op[139:128], rkd_value[127:96], src2[95:64], src1[63:32], pc[31:0]}
- es_to_ms_valid  out  1  instruction offered to mem_stage
- es_to_ms_bus  out  82  {addr_low[81:80], mem_we[79], ld_w[78], ld_b[77], ld_bu[76], ld_h[75], ld_hu[74], st_w[73], st_b[72], st_h[71], res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}
- es_forward  out  72  {pc[71:40], res_from_mem[39], result[38:7], dest[6:2], gr_we[1], es_valid[0]}
- data_sram_en  out  1  request strobe
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

Behaviour:
- Handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - es_to_ms_valid = es_valid & es_ready_go.
  - On a clock edge with es_allowin high: es_valid <= ds_to_es_valid.
  - On ds_to_es_valid & es_allowin: the bus register latches ds_to_es_bus.
- Reset (reset = 0, asynchronous):
  - es_valid = 0, bus register = 0, divider state = IDLE, divider registers = 0.
  - Outputs during reset: es_to_ms_valid = 0, data_sram_en = 0, data_sram_we = 0, es_allowin = 1, es_forward[0] = 0.
  - Reset asserted mid-division abandons the operation; no result is delivered.
- Result mux:
  - result = selected divider output if any div_op bit is set, else alu result.
  - addr_low = alu_result[1:0].
- es_ready_go = 1 for non-divide instructions. For divide instructions, es_ready_go = 1 only in divider state DONE.
- Divider FSM (restoring radix-2, unsigned core):
  - IDLE: when es_valid & |div_op, capture |src1| and |src2|, with signed interpretation for div_w/mod_w. Record sign_q = s1^s2 and sign_r = s1, then go to BUSY with count = 0.
  - BUSY: one quotient bit per cycle. Exit to DONE when count = 31, i.e. after 32 cycles.
  - DONE: apply sign fix (negate q if sign_q, negate r if sign_r) and hold the result. Return to IDLE on the handoff (es_valid & es_ready_go & ms_allowin).
  - Minimum ES residency for a divide: 34 cycles (1 IDLE + 32 BUSY + 1 DONE).
  - Divide by zero: no early exit. Delivers q = 0xFFFFFFFF and r = dividend for unsigned ops; signed ops apply the sign fix to these raw values.
  - 0x80000000 / -1 (signed): q = 0x80000000, r = 0.
  - A back-to-back divide restarts from IDLE in the cycle after the handoff.
- Memory request:
  - data_sram_en = es_valid & (res_from_mem | mem_we) & ms_allowin. Loads and stores are single-cycle (es_ready_go = 1).
  - data_sram_addr = alu_result.
  - st_w: we = 4'b1111, wdata = rkd.
  - st_h: we = 4'b0011 << {addr[1],1'b0}, wdata = {2{rkd[15:0]}}.
  - st_b: we = 4'b0001 << addr[1:0], wdata = {4{rkd[7:0]}}.
  - data_sram_we = 0 unless mem_we & es_valid.
  - The request fires only in the cycle the instruction moves to mem_stage, so mem_stage sees rdata in its first cycle.
- Forwarding: es_forward reflects the current ES contents combinationally. Bit 39 (res_from_mem) tells decode that a load result is not yet available.
- Simultaneous events: with es_ready_go & ms_allowin & ds_to_es_valid in the same cycle, the new instruction is latched and the old one is handed off in the same edge.

Optional Feature:
- Macro EXE_DIV_EN.
- Defined: divider FSM present as specified above.
- Undefined: no divider logic. div_op is ignored, result = alu result, es_ready_go = 1 always, and every instruction spends one cycle in ES.

Test Plan:
- add with src1 = 5, src2 = 7, ms_allowin = 1 -> next cycle es_to_ms_valid = 1, es_to_ms_bus[63:32] = 12, es_forward[0] = 1.
- div_w src1 = -7 (0xFFFFFFF9), src2 = 2 -> es_to_ms_valid low for 33 cycles, then result 0xFFFFFFFD; mod_w on the same operands -> 0xFFFFFFFF.
- div_wu src2 = 0, src1 = 0x1234 -> 0xFFFFFFFF; mod_wu -> 0x1234. Also div_w 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- st_b addr 0x1003, rkd = 0xAABBCCDD -> data_sram_en = 1, we = 4'b1000, wdata = 0xDDDDDDDD; st_h addr 0x1002 -> we = 4'b1100.
- Divide in DONE with ms_allowin = 0 for 5 cycles -> result held, es_allowin = 0, no request; on ms_allowin = 1 the handoff occurs and es_allowin = 1 in the same cycle.
- reset driven low during BUSY cycle 10 -> es_valid = 0, data_sram_en = 0 immediately, without waiting for a clock edge; after release a new div completes in 34 cycles.

Source files
------------

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - LoongArch execute stage: ALU, iterative divider (macro EXE_DIV_EN), data SRAM request
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic        use_sub;
    logic [31:0] adder_b;
    logic [32:0] adder_sum;
    logic        slt_res;
    logic        sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;

    // slt/sltu reuse the subtractor: a - b = a + ~b + 1
    assign use_sub   = alu_op[1] | alu_op[2] | alu_op[3];
    assign adder_b   = use_sub ? ~alu_src2 : alu_src2;
    assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'b0, use_sub};
    assign slt_res   = (alu_src1[31] & ~alu_src2[31])
                     | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    assign sltu_res  = ~adder_sum[32];
    assign sll_res   = alu_src1 << alu_src2[4:0];
    assign srl_res   = alu_src1 >> alu_src2[4:0];
    assign sra_res   = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

    always_comb begin
        alu_result = ({32{alu_op[0] | alu_op[1]}} & adder_sum[31:0])
                   | ({32{alu_op[2]}}  & {31'b0, slt_res})
                   | ({32{alu_op[3]}}  & {31'b0, sltu_res})
                   | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                   | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                   | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[8]}}  & sll_res)
                   | ({32{alu_op[9]}}  & srl_res)
                   | ({32{alu_op[10]}} & sra_res)
                   | ({32{alu_op[11]}} & alu_src2);
    end
endmodule

module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 160,
    parameter int ES_TO_MS_BUS_WD = 82,
    parameter int ES_FORWARD_WD   = 72
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_FORWARD_WD-1:0]   es_forward,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);
    logic                       es_valid;
    logic                       es_ready_go;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus;

    logic        mem_we;
    logic [7:0]  ldst_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  div_op;
    logic [11:0] alu_op;
    logic [31:0] rkd_value;
    logic [31:0] src2;
    logic [31:0] src1;
    logic [31:0] pc;
    logic        st_w;
    logic        st_b;
    logic        st_h;

    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic [3:0]  store_we;
    logic [31:0] store_wdata;

    assign mem_we       = es_bus[159];
    assign ldst_op      = es_bus[158:151];
    assign res_from_mem = es_bus[150];
    assign gr_we        = es_bus[149];
    assign dest         = es_bus[148:144];
    assign div_op       = es_bus[143:140];
    assign alu_op       = es_bus[139:128];
    assign rkd_value    = es_bus[127:96];
    assign src2         = es_bus[95:64];
    assign src1         = es_bus[63:32];
    assign pc           = es_bus[31:0];
    assign st_w         = es_bus[153];
    assign st_b         = es_bus[152];
    assign st_h         = es_bus[151];

    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_to_es_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            es_bus <= '0;
        end else if (ds_to_es_valid && es_allowin) begin
            es_bus <= ds_to_es_bus;
        end
    end

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

`ifdef EXE_DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_quo;
    logic [31:0] div_dvs;
    logic [31:0] div_rem;
    logic        sign_q;
    logic        sign_r;

    logic        is_div;
    logic        div_signed;
    logic        s1;
    logic        s2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] rem_sh;
    logic        q_bit;
    logic [32:0] rem_next;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] div_result;

    assign is_div     = |div_op;
    assign div_signed = div_op[0] | div_op[2];
    assign s1         = div_signed & src1[31];
    assign s2         = div_signed & src2[31];
    assign abs1       = s1 ? (32'd0 - src1) : src1;
    assign abs2       = s2 ? (32'd0 - src2) : src2;

    // div_quo starts as the dividend and fills with quotient bits from the right
    assign rem_sh   = {div_rem, div_quo[31]};
    assign q_bit    = rem_sh >= {1'b0, div_dvs};
    assign rem_next = q_bit ? (rem_sh - {1'b0, div_dvs}) : rem_sh;

    assign q_fix      = sign_q ? (32'd0 - div_quo) : div_quo;
    assign r_fix      = sign_r ? (32'd0 - div_rem) : div_rem;
    assign div_result = (div_op[3] | div_op[2]) ? r_fix : q_fix;

    assign es_ready_go = !is_div || (div_state == DIV_DONE);
    assign es_result   = is_div ? div_result : alu_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= 5'd0;
            div_quo   <= 32'd0;
            div_dvs   <= 32'd0;
            div_rem   <= 32'd0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (es_valid && is_div) begin
                        div_quo   <= abs1;
                        div_dvs   <= abs2;
                        div_rem   <= 32'd0;
                        div_cnt   <= 5'd0;
                        sign_q    <= s1 ^ s2;
                        sign_r    <= s1;
                        div_state <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    div_rem <= rem_next[31:0];
                    div_quo <= {div_quo[30:0], q_bit};
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (es_valid && es_ready_go && ms_allowin) begin
                        div_state <= DIV_IDLE;
                    end
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end
`else
    logic unused_div_op;

    assign unused_div_op = ^div_op;
    assign es_ready_go   = 1'b1;
    assign es_result     = alu_result;
`endif

    always_comb begin
        store_we    = 4'b0000;
        store_wdata = rkd_value;
        if (st_b) begin
            store_we    = 4'b0001 << alu_result[1:0];
            store_wdata = {4{rkd_value[7:0]}};
        end else if (st_h) begin
            store_we    = 4'b0011 << {alu_result[1], 1'b0};
            store_wdata = {2{rkd_value[15:0]}};
        end else if (st_w) begin
            store_we    = 4'b1111;
        end
    end

    // The request fires only on the handoff cycle so mem_stage sees rdata immediately
    assign data_sram_en    = es_valid && (res_from_mem || mem_we) && ms_allowin;
    assign data_sram_we    = (es_valid && mem_we) ? store_we : 4'b0000;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = store_wdata;

    assign es_to_ms_bus = {alu_result[1:0], mem_we, ldst_op, res_from_mem, gr_we,
                           dest, es_result, pc};
    assign es_forward   = {pc, res_from_mem, es_result, dest, gr_we, es_valid};
endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage with a cycle-level reference model
module tb_exe_stage;
    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [159:0] ds_to_es_bus;
    logic         es_to_ms_valid;
    logic [81:0]  es_to_ms_bus;
    logic [71:0]  es_forward;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [11:0] OP_SUB = 12'h002;
    localparam logic [11:0] OP_SLT = 12'h004;
    localparam logic [11:0] OP_AND = 12'h010;
    localparam logic [11:0] OP_SLL = 12'h100;
    localparam logic [11:0] OP_SRA = 12'h400;
    localparam logic [11:0] OP_LUI = 12'h800;
    localparam logic [3:0]  DIV_W  = 4'b0001;
    localparam logic [3:0]  DIV_WU = 4'b0010;
    localparam logic [3:0]  MOD_W  = 4'b0100;
    localparam logic [3:0]  MOD_WU = 4'b1000;
    localparam logic [7:0]  LD_W   = 8'h80;
    localparam logic [7:0]  ST_W   = 8'h04;
    localparam logic [7:0]  ST_B   = 8'h02;
    localparam logic [7:0]  ST_H   = 8'h01;
`ifdef EXE_DIV_EN
    localparam int DIV_LAT = 33;
`else
    localparam int DIV_LAT = 0;
`endif

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_forward      (es_forward),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [159:0] mk(input logic mwe, input logic [7:0] ldst, input logic rfm,
                                        input logic gwe, input logic [4:0] dst, input logic [3:0] dop,
                                        input logic [11:0] aop, input logic [31:0] rkd,
                                        input logic [31:0] s2, input logic [31:0] s1, input logic [31:0] pcv);
        return {mwe, ldst, rfm, gwe, dst, dop, aop, rkd, s2, s1, pcv};
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] with_div, input logic [31:0] without_div);
`ifdef EXE_DIV_EN
        return with_div;
`else
        return without_div;
`endif
    endfunction

    // ---------------- reference model ----------------
    function automatic logic ref_is_div(input logic [159:0] b);
`ifdef EXE_DIV_EN
        return |b[143:140];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[0])  return a + b;
        if (op[1])  return a - b;
        if (op[2])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[3])  return (a < b) ? 32'd1 : 32'd0;
        if (op[4])  return a & b;
        if (op[5])  return ~(a | b);
        if (op[6])  return a | b;
        if (op[7])  return a ^ b;
        if (op[8])  return a << b[4:0];
        if (op[9])  return a >> b[4:0];
        if (op[10]) return $unsigned($signed(a) >>> b[4:0]);
        if (op[11]) return b;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] q;
        logic [31:0] r;
        sgn = op[0] | op[2];
        if (b == 32'd0) begin
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (op[3] | op[2]) ? r : q;
    endfunction

    function automatic logic [31:0] ref_addr(input logic [159:0] b);
        return ref_alu(b[139:128], b[63:32], b[95:64]);
    endfunction

    function automatic logic [31:0] ref_result(input logic [159:0] b);
        if (ref_is_div(b)) return ref_div(b[143:140], b[63:32], b[95:64]);
        return ref_addr(b);
    endfunction

    function automatic logic [3:0] ref_we(input logic [159:0] b);
        logic [31:0] a;
        a = ref_addr(b);
        if (!b[159]) return 4'b0000;
        if (b[152]) begin
            case (a[1:0])
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
            endcase
        end
        if (b[151]) return a[1] ? 4'b1100 : 4'b0011;
        if (b[153]) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [159:0] b);
        if (b[152]) return {4{b[103:96]}};
        if (b[151]) return {2{b[111:96]}};
        return b[127:96];
    endfunction

    // Model of ES occupancy: which instruction is held and for how many cycles
    logic         m_valid;
    logic [159:0] m_bus;
    int           m_age;
    logic         m_ready;

    always_comb m_ready = !ref_is_div(m_bus) || (m_age >= 33);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_bus   <= '0;
            m_age   <= 0;
        end else if (!m_valid || (m_ready && ms_allowin)) begin
            m_valid <= ds_to_es_valid;
            if (ds_to_es_valid) m_bus <= ds_to_es_bus;
            m_age   <= 0;
        end else begin
            m_age   <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("es_allowin", 82'(es_allowin), 82'(!m_valid || (m_ready && ms_allowin)));
            chk("es_to_ms_valid", 82'(es_to_ms_valid), 82'(m_valid && m_ready));
            chk("fwd_valid", 82'(es_forward[0]), 82'(m_valid));
            chk("sram_en", 82'(data_sram_en), 82'(m_valid && (m_bus[150] || m_bus[159]) && ms_allowin));
            chk("sram_we", 82'(data_sram_we), 82'(m_valid ? ref_we(m_bus) : 4'b0000));
            if (m_valid) begin
                chk("sram_addr", 82'(data_sram_addr), 82'(ref_addr(m_bus)));
                chk("fwd_info", 82'({es_forward[71:39], es_forward[6:1]}),
                    82'({m_bus[31:0], m_bus[150], m_bus[148:144], m_bus[149]}));
                if (m_bus[159] && data_sram_en)
                    chk("sram_wdata", 82'(data_sram_wdata), 82'(ref_wdata(m_bus)));
                if (m_ready) begin
                    chk("es_to_ms_bus", es_to_ms_bus,
                        {ref_addr(m_bus) & 32'd3, m_bus[159:149], m_bus[148:144],
                         ref_result(m_bus), m_bus[31:0]} & {2'b11, 80'hFFFF_FFFF_FFFF_FFFF_FFFF} |
                        {ref_addr(m_bus)[1:0], 80'h0} | {2'b00, m_bus[159:149], m_bus[148:144],
                         ref_result(m_bus), m_bus[31:0]});
                    chk("fwd_result", 82'(es_forward[38:7]), 82'(ref_result(m_bus)));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [159:0] b);
        int n;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
        n = 0;
        while (!es_allowin && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: es_allowin stuck low, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic run_one(input string name, input logic [159:0] b,
                           input logic [31:0] exp_res, input int exp_wait);
        int n;
        send(b);
        ds_to_es_valid = 1'b0;
        chk({name, " fwd_valid"}, 82'(es_forward[0]), 82'(1));
        n = 0;
        while (!es_to_ms_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, 82'(n), 82'(exp_wait));
        chk({name, " result"}, 82'(es_to_ms_bus[63:32]), 82'(exp_res));
        @(posedge clk); #1;
    endtask

    task automatic mem_one(input string name, input logic [159:0] b, input logic [3:0] exp_we,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
        send(b);
        ds_to_es_valid = 1'b0;
        chk({name, " en"}, 82'(data_sram_en), 82'(1));
        chk({name, " we"}, 82'(data_sram_we), 82'(exp_we));
        chk({name, " addr"}, 82'(data_sram_addr), 82'(exp_addr));
        if (exp_we != 4'b0000) chk({name, " wdata"}, 82'(data_sram_wdata), 82'(exp_wdata));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset          = 1'b0;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #3;
        chk("rst es_allowin", 82'(es_allowin), 82'(1));
        chk("rst es_to_ms_valid", 82'(es_to_ms_valid), 82'(0));
        chk("rst sram_en", 82'(data_sram_en), 82'(0));
        chk("rst sram_we", 82'(data_sram_we), 82'(0));
        chk("rst fwd_valid", 82'(es_forward[0]), 82'(0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        run_one("add", mk(0, 8'h0, 0, 1, 5'd3, 4'h0, OP_ADD, 32'd0, 32'd7, 32'd5, 32'h1c00_0000), 32'd12, 0);
        run_one("sub", mk(0, 8'h0, 0, 1, 5'd4, 4'h0, OP_SUB, 32'd0, 32'd7, 32'd5, 32'h1c00_0004), 32'hFFFF_FFFE, 0);
        run_one("slt", mk(0, 8'h0, 0, 1, 5'd5, 4'h0, OP_SLT, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'h1c00_0008), 32'd1, 0);
        run_one("sll", mk(0, 8'h0, 0, 1, 5'd6, 4'h0, OP_SLL, 32'd0, 32'd31, 32'd1, 32'h1c00_000c), 32'h8000_0000, 0);
        run_one("sra", mk(0, 8'h0, 0, 1, 5'd7, 4'h0, OP_SRA, 32'd0, 32'd4, 32'h8000_0000, 32'h1c00_0010), 32'hF800_0000, 0);
        run_one("and", mk(0, 8'h0, 0, 1, 5'd8, 4'h0, OP_AND, 32'd0, 32'h0FF0, 32'hF0F0, 32'h1c00_0014), 32'h00F0, 0);
        run_one("lui", mk(0, 8'h0, 0, 1, 5'd9, 4'h0, OP_LUI, 32'd0, 32'h1234_5000, 32'd0, 32'h1c00_0018), 32'h1234_5000, 0);

        run_one("div_w", mk(0, 8'h0, 0, 1, 5'd10, DIV_W, OP_ADD, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'h1c00_0020),
                pick(32'hFFFF_FFFD, 32'hFFFF_FFFB), DIV_LAT);
        run_one("mod_w", mk(0, 8'h0, 0, 1, 5'd11, MOD_W, OP_ADD, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'h1c00_0024),
                pick(32'hFFFF_FFFF, 32'hFFFF_FFFB), DIV_LAT);
        run_one("div_wu0", mk(0, 8'h0, 0, 1, 5'd12, DIV_WU, OP_ADD, 32'd0, 32'd0, 32'h1234, 32'h1c00_0028),
                pick(32'hFFFF_FFFF, 32'h1234), DIV_LAT);
        run_one("mod_wu0", mk(0, 8'h0, 0, 1, 5'd13, MOD_WU, OP_ADD, 32'd0, 32'd0, 32'h1234, 32'h1c00_002c),
                32'h1234, DIV_LAT);
        run_one("div_w_ovf", mk(0, 8'h0, 0, 1, 5'd14, DIV_W, OP_ADD, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1c00_0030),
                pick(32'h8000_0000, 32'h7FFF_FFFF), DIV_LAT);
        run_one("div_w0", mk(0, 8'h0, 0, 1, 5'd15, DIV_W, OP_ADD, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'h1c00_0034),
                pick(32'd1, 32'hFFFF_FFF9), DIV_LAT);
        run_one("mod_w0", mk(0, 8'h0, 0, 1, 5'd16, MOD_W, OP_ADD, 32'd0, 32'd0, 32'hFFFF_FFF9, 32'h1c00_0038),
                32'hFFFF_FFF9, DIV_LAT);
        run_one("div_wu", mk(0, 8'h0, 0, 1, 5'd17, DIV_WU, OP_ADD, 32'd0, 32'd7, 32'd100, 32'h1c00_003c),
                pick(32'd14, 32'd107), DIV_LAT);
        run_one("mod_wu", mk(0, 8'h0, 0, 1, 5'd18, MOD_WU, OP_ADD, 32'd0, 32'd7, 32'd100, 32'h1c00_0040),
                pick(32'd2, 32'd107), DIV_LAT);

        mem_one("st_b", mk(1, ST_B, 0, 0, 5'd0, 4'h0, OP_ADD, 32'hAABB_CCDD, 32'd3, 32'h1000, 32'h1c00_0050),
                4'b1000, 32'hDDDD_DDDD, 32'h1003);
        mem_one("st_h", mk(1, ST_H, 0, 0, 5'd0, 4'h0, OP_ADD, 32'hAABB_CCDD, 32'd2, 32'h1000, 32'h1c00_0054),
                4'b1100, 32'hCCDD_CCDD, 32'h1002);
        mem_one("st_w", mk(1, ST_W, 0, 0, 5'd0, 4'h0, OP_ADD, 32'hAABB_CCDD, 32'd0, 32'h1000, 32'h1c00_0058),
                4'b1111, 32'hAABB_CCDD, 32'h1000);
        send(mk(0, LD_W, 1, 1, 5'd20, 4'h0, OP_ADD, 32'd0, 32'd4, 32'h2000, 32'h1c00_005c));
        ds_to_es_valid = 1'b0;
        chk("ld_w fwd_load", 82'(es_forward[39]), 82'(1));
        chk("ld_w en", 82'(data_sram_en), 82'(1));
        chk("ld_w we", 82'(data_sram_we), 82'(0));
        @(posedge clk); #1;

        // Back-to-back stream exercising same-edge latch and handoff
        send(mk(0, 8'h0, 0, 1, 5'd1, 4'h0, OP_ADD, 32'd0, 32'd1, 32'd10, 32'h1c00_0100));
        send(mk(0, 8'h0, 0, 1, 5'd2, 4'h0, OP_SUB, 32'd0, 32'd3, 32'd10, 32'h1c00_0104));
        send(mk(1, ST_B, 0, 0, 5'd0, 4'h0, OP_ADD, 32'h0000_0055, 32'd1, 32'h3000, 32'h1c00_0108));
        send(mk(0, 8'h0, 0, 1, 5'd3, DIV_W, OP_ADD, 32'd0, 32'd3, 32'd100, 32'h1c00_010c));
        send(mk(0, 8'h0, 0, 1, 5'd4, MOD_WU, OP_ADD, 32'd0, 32'd3, 32'd100, 32'h1c00_0110));
        send(mk(0, LD_W, 1, 1, 5'd5, 4'h0, OP_ADD, 32'd0, 32'd8, 32'h4000, 32'h1c00_0114));
        ds_to_es_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Stalled handoff: result must hold while mem_stage refuses
        ms_allowin = 1'b0;
        send(mk(0, 8'h0, 0, 1, 5'd21, DIV_W, OP_ADD, 32'd0, 32'd2, 32'hFFFF_FFF9, 32'h1c00_0200));
        ds_to_es_valid = 1'b0;
        n = 0;
        while (!es_to_ms_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold latency", 82'(n), 82'(DIV_LAT));
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", 82'(es_to_ms_valid), 82'(1));
            chk("hold allowin", 82'(es_allowin), 82'(0));
            chk("hold sram_en", 82'(data_sram_en), 82'(0));
            chk("hold result", 82'(es_to_ms_bus[63:32]), 82'(pick(32'hFFFF_FFFD, 32'hFFFF_FFFB)));
            @(posedge clk); #1;
        end
        ms_allowin = 1'b1;
        #1;
        chk("release allowin", 82'(es_allowin), 82'(1));
        @(posedge clk); #1;
        chk("after handoff empty", 82'(es_forward[0]), 82'(0));

        // Asynchronous reset in the middle of a divide
        ms_allowin = 1'b0;
        send(mk(0, 8'h0, 0, 1, 5'd22, DIV_WU, OP_ADD, 32'd0, 32'd3, 32'd1000, 32'h1c00_0300));
        ds_to_es_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("pre-reset occupied", 82'(es_forward[0]), 82'(1));
        #1;
        reset = 1'b0;
        #1;
        chk("async rst fwd_valid", 82'(es_forward[0]), 82'(0));
        chk("async rst to_ms_valid", 82'(es_to_ms_valid), 82'(0));
        chk("async rst sram_en", 82'(data_sram_en), 82'(0));
        chk("async rst allowin", 82'(es_allowin), 82'(1));
        @(posedge clk); #1;
        reset      = 1'b1;
        ms_allowin = 1'b1;
        run_one("div after reset", mk(0, 8'h0, 0, 1, 5'd23, DIV_WU, OP_ADD, 32'd0, 32'd3, 32'd1000, 32'h1c00_0304),
                pick(32'd333, 32'd1003), DIV_LAT);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
